serial_to_parallel: RTL and testbench

- Receive-side counterpart of parallel_to_serial: deserializes an LSB-first serial bitstream into DATA_WIDTH-bit words.
- Optionally checks one trailing even-parity bit per word.
- Presents each completed word on a valid/ready output port.
- Sits after the serializer in loopback benches and in the RX datapath; the shift register and output register are separate, so reception continues while a word waits for acceptance.

---
 rtl/serial_to_parallel.sv | 124 ++++++++++++
 tb/tb_serial_to_parallel.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel.sv
// LSB-first serial-to-parallel receiver with optional trailing even-parity check.
// Completed words are held in a separate output register behind a valid/ready handshake.
module serial_to_parallel #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serial_in,
    input  logic                  serial_valid,
    input  logic                  serial_start,
    output logic [DATA_WIDTH-1:0] parallel_out,
    output logic                  parallel_valid,
    input  logic                  parallel_ready,
    output logic                  parity_err,
    output logic                  overrun,
    output logic                  frame_err
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   merged_word;
    logic [DATA_WIDTH-1:0]   done_word;
    logic                    last_data_bit;
    logic                    word_done;
    logic                    word_perr;
    logic                    slot_free;

    // The shift register with the current bit already merged in; in PAR the data is complete.
    always_comb begin
        merged_word            = shift_reg;
        merged_word[bit_cnt]   = serial_in;
        last_data_bit          = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
        word_done              = 1'b0;
        word_perr              = 1'b0;
        done_word              = merged_word;
        if (serial_valid && !serial_start) begin
            case (state)
                DATA: begin
                    if (last_data_bit && PARITY_EN == 0) begin
                        word_done = 1'b1;
                    end
                end
                PAR: begin
                    word_done = 1'b1;
                    done_word = shift_reg;
                    word_perr = (^shift_reg) ^ serial_in;
                end
                default: ;
            endcase
        end
        slot_free = !parallel_valid || parallel_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            parallel_out   <= '0;
            parallel_valid <= 1'b0;
            parity_err     <= 1'b0;
            overrun        <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;

            // A start always begins a fresh frame; outside IDLE it aborts the partial one.
            if (serial_valid) begin
                if (serial_start) begin
                    if (state != IDLE) begin
                        frame_err <= 1'b1;
                    end
                    shift_reg <= DATA_WIDTH'(serial_in);
                    bit_cnt   <= CNT_W'(1);
                    state     <= DATA;
                end else begin
                    case (state)
                        DATA: begin
                            shift_reg <= merged_word;
                            if (last_data_bit) begin
                                bit_cnt <= '0;
                                state   <= (PARITY_EN != 0) ? PAR : IDLE;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        PAR: begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end
                        default: ;
                    endcase
                end
            end

            if (parallel_valid && parallel_ready) begin
                parallel_valid <= 1'b0;
            end

            // A word finishing while the slot is still held is dropped, not queued.
            if (word_done) begin
                if (slot_free) begin
                    parallel_out   <= done_word;
                    parity_err     <= word_perr;
                    parallel_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel: a bit-queue reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_serial_to_parallel;

    localparam int W     = 8;
    localparam int FRAME = W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         serial_in = 1'b0;
    logic         serial_valid = 1'b0;
    logic         serial_start = 1'b0;
    logic [W-1:0] parallel_out;
    logic         parallel_valid;
    logic         parallel_ready = 1'b1;
    logic         parity_err;
    logic         overrun;
    logic         frame_err;

    int errors = 0;
    int checks = 0;

    serial_to_parallel #(.DATA_WIDTH(W), .PARITY_EN(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .serial_valid   (serial_valid),
        .serial_start   (serial_start),
        .parallel_out   (parallel_out),
        .parallel_valid (parallel_valid),
        .parallel_ready (parallel_ready),
        .parity_err     (parity_err),
        .overrun        (overrun),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects frame bits in a queue and decides words from whole frames.
    logic         bitq[$];
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_out = '0;
    logic         exp_perr = 1'b0;
    logic         exp_overrun = 1'b0;
    logic         exp_frame_err = 1'b0;
    logic [W-1:0] mdl_word;
    logic         mdl_par;
    logic         mdl_done;
    logic         mdl_free;

    always @(posedge clk) begin
        exp_overrun   = 1'b0;
        exp_frame_err = 1'b0;
        if (rst) begin
            bitq.delete();
            exp_valid = 1'b0;
            exp_out   = '0;
            exp_perr  = 1'b0;
        end else begin
            mdl_done = 1'b0;
            if (serial_valid) begin
                if (serial_start) begin
                    if (bitq.size() != 0) exp_frame_err = 1'b1;
                    bitq.delete();
                    bitq.push_back(serial_in);
                end else if (bitq.size() != 0) begin
                    bitq.push_back(serial_in);
                end
                if (bitq.size() == FRAME) begin
                    mdl_word = '0;
                    mdl_par  = 1'b0;
                    for (int i = 0; i < FRAME; i++) begin
                        if (i < W) mdl_word[i] = bitq[i];
                        mdl_par = mdl_par ^ bitq[i];
                    end
                    mdl_done = 1'b1;
                    bitq.delete();
                end
            end
            mdl_free = !exp_valid || parallel_ready;
            if (exp_valid && parallel_ready) exp_valid = 1'b0;
            if (mdl_done) begin
                if (mdl_free) begin
                    exp_valid = 1'b1;
                    exp_out   = mdl_word;
                    exp_perr  = mdl_par;
                end else begin
                    exp_overrun = 1'b1;
                end
            end
        end
    end

    bit           cmp_en = 1'b0;
    logic [W-1:0] got[$];
    int           ov_cnt = 0;
    int           fe_cnt = 0;

    // Per-cycle comparison against the model, plus accepted-word and pulse logging.
    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("model_valid", 32'(parallel_valid), 32'(exp_valid));
            if (exp_valid) begin
                check_output("model_out", 32'(parallel_out), 32'(exp_out));
                check_output("model_perr", 32'(parity_err), 32'(exp_perr));
            end
            check_output("model_overrun", 32'(overrun), 32'(exp_overrun));
            check_output("model_frame_err", 32'(frame_err), 32'(exp_frame_err));
        end
        if (!rst) begin
            if (parallel_valid && parallel_ready) got.push_back(parallel_out);
            if (overrun) ov_cnt++;
            if (frame_err) fe_cnt++;
        end
    end

    task automatic drive_bit(input logic b, input logic start);
        serial_valid = 1'b1;
        serial_in    = b;
        serial_start = start;
        @(posedge clk);
        #1;
        serial_valid = 1'b0;
        serial_start = 1'b0;
    endtask

    task automatic idle(input int n);
        serial_valid = 1'b0;
        serial_start = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic [W-1:0] w, input logic p);
        for (int i = 0; i < W; i++) drive_bit(w[i], i == 0);
        drive_bit(p, 1'b0);
    endtask

    task automatic check_got(input string name, input logic [W-1:0] exp_list[$]);
        check_output({name, "_count"}, 32'(got.size()), 32'(exp_list.size()));
        for (int i = 0; i < exp_list.size() && i < got.size(); i++)
            check_output({name, "_word"}, 32'(got[i]), 32'(exp_list[i]));
    endtask

    initial begin
        logic [W-1:0] exp_list[$];
        logic [W-1:0] w81;
        int ov0;
        int fe0;

        rst = 1'b1;
        idle(2);
        check_output("reset_valid", 32'(parallel_valid), 32'd0);
        check_output("reset_out", 32'(parallel_out), 32'd0);
        check_output("reset_perr", 32'(parity_err), 32'd0);
        check_output("reset_overrun", 32'(overrun), 32'd0);
        check_output("reset_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;
        idle(2);

        // 0xA5, correct parity 0: valid exactly one cycle after the parity bit
        apply_stimulus(8'hA5, 1'b0);
        check_output("a5_valid", 32'(parallel_valid), 32'd1);
        check_output("a5_out", 32'(parallel_out), 32'hA5);
        check_output("a5_perr", 32'(parity_err), 32'd0);
        idle(1);
        check_output("a5_valid_drop", 32'(parallel_valid), 32'd0);

        // 0x3C with wrong then right parity
        apply_stimulus(8'h3C, 1'b1);
        check_output("3c_bad_out", 32'(parallel_out), 32'h3C);
        check_output("3c_bad_perr", 32'(parity_err), 32'd1);
        idle(1);
        apply_stimulus(8'h3C, 1'b0);
        check_output("3c_good_perr", 32'(parity_err), 32'd0);
        idle(2);

        // 0x81 with stalls inside the frame
        w81 = 8'h81;
        for (int i = 0; i < W; i++) begin
            drive_bit(w81[i], i == 0);
            if (i == 2) idle(3);
            if (i == 6) idle(5);
        end
        drive_bit(1'b0, 1'b0);
        check_output("81_valid", 32'(parallel_valid), 32'd1);
        check_output("81_out", 32'(parallel_out), 32'h81);
        check_output("81_perr", 32'(parity_err), 32'd0);
        idle(2);

        // Overrun: ready low, second word dropped
        got.delete();
        ov0 = ov_cnt;
        parallel_ready = 1'b0;
        apply_stimulus(8'h11, 1'b0);
        apply_stimulus(8'h22, 1'b0);
        check_output("ovr_pulse", 32'(overrun), 32'd1);
        check_output("ovr_held", 32'(parallel_out), 32'h11);
        idle(3);
        check_output("ovr_still_held", 32'(parallel_out), 32'h11);
        parallel_ready = 1'b1;
        idle(3);
        check_output("ovr_count", 32'(ov_cnt - ov0), 32'd1);
        exp_list = '{8'h11};
        check_got("ovr", exp_list);

        // Premature start aborts 4-bit partial frame
        got.delete();
        fe0 = fe_cnt;
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        apply_stimulus(8'hF0, 1'b0);
        idle(2);
        check_output("fe_count", 32'(fe_cnt - fe0), 32'd1);
        exp_list = '{8'hF0};
        check_got("fe", exp_list);

        // Reset mid-frame, then 0x5A
        got.delete();
        for (int i = 0; i < 5; i++) drive_bit(1'b1, i == 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        apply_stimulus(8'h5A, 1'b0);
        idle(2);
        exp_list = '{8'h5A};
        check_got("rst", exp_list);

        // Ten back-to-back frames with no idle cycles
        got.delete();
        exp_list.delete();
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(W'(k), ^(W'(k)));
            exp_list.push_back(W'(k));
        end
        idle(3);
        check_got("b2b", exp_list);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
